fan_speed_sel: RTL
==================

// Module: fan_speed_sel
// PURPOSE
//  Upstream stage of the fan PWM generator. Converts audio magnitude samples into the 2-bit
//  speed code that the PWM generator consumes (HIGH=2'b00, MEDIUM=2'b01, LOW=2'b10, OFF=2'b11).
//  Captures the peak magnitude per fixed window, quantises it against three thresholds, and
//  applies hysteresis and minimum dwell so the fan does not chatter on music transients.
// PARAMETERS
//  SW         12     sample/level width, unsigned magnitude
//  WIN_US     50000  window length in clk_us cycles (1 us each); >= 2
//  TH_LOW     256    level >= TH_LOW enables LOW (TH1)
//  TH_MED     1024   level >= TH_MED enables MEDIUM (TH2)
//  TH_HIGH    2560   level >= TH_HIGH enables HIGH (TH3); TH1<TH2<TH3 required
//  HYST       64     down-step margin below the current level's threshold
//  DWELL_WIN  4      windows after a change before a down-step is allowed
// PORTS
//  clk_us        in   1   1 MHz system tick clock
//  rst           in   1   synchronous reset, active-high
//  enable        in   1   0 = force OFF and clear state (synchronous)
//  sample_valid  in   1   sample qualifies this cycle
//  sample        in   SW  unsigned audio magnitude
//  speed         out  2   speed code to PWM generator, registered
//  level         out  SW  last completed window peak, registered
//  speed_change  out  1   1-cycle pulse on the edge where speed changes
// BEHAVIOUR
//  Reset (rst=1 at clk_us edge): speed=2'b11, level=0, speed_change=0; win_cnt, peak, idx,
//   dwell_cnt=0. rst has priority over enable.
//  enable=0 (rst=0): same register values as reset. First cycle with enable=1 is win_cnt=0.
//  Internal index idx: 0=OFF,1=LOW,2=MED,3=HIGH; speed = ~idx (always registered, no glitch).
//  Window: win_cnt counts 0..WIN_US-1 and wraps. Each cycle with sample_valid:
//   peak <= max(peak, sample). Samples with sample_valid=0 are ignored.
//  Window end (win_cnt==WIN_US-1): fin = max(peak, sample_valid ? sample : 0), which includes
//   the final-cycle sample. At that edge: level <= fin, peak <= 0, and the decision below is applied.
//  Decision at window end: r = count of {TH1,TH2,TH3} that are <= fin (0..3).
//   r > idx: idx <= idx+1 (one step per window max), dwell_cnt <= 0, speed_change=1.
//   r < idx and fin < TH[idx]-HYST (clamped at 0) and dwell_cnt >= DWELL_WIN:
//     idx <= idx-1, dwell_cnt <= 0, speed_change=1.
//   Otherwise: idx held; dwell_cnt <= min(dwell_cnt+1, DWELL_WIN).
//   A down-step therefore occurs no earlier than DWELL_WIN+1 windows after the last change.
//   Up-steps are never dwell-gated.
//  speed_change is 0 on every cycle other than a changing window-end edge. enable=0 forcing
//   OFF does not pulse speed_change.
//  Latency: speed/level update on the same edge that closes the window; no other updates.
//  Arithmetic: all unsigned SW-bit; TH-HYST computed with saturation at 0; peak cannot overflow.
// TESTING (bench params: WIN_US=8, TH 256/1024/2560, HYST=64, DWELL_WIN=2)
//  rst=1 for 2 cycles, enable=1 -> speed=11, level=0, speed_change=0; cycle after rst falls, win_cnt=0.
//  sample=3000 valid every cycle for 3 windows -> speed 10, 01, 00 at ends of windows 1, 2, 3;
//   level=3000; speed_change one pulse per window end.
//  At HIGH, with dwell satisfied: window peak 2520 -> stays 00 (>=2496); peak 2400 -> 01.
//  At MEDIUM just reached, then valid samples=0: speed stays 01 for 2 windows, 10 at window 3,
//   11 at window 6; level=0.
//  Only valid sample is 1100 on the last window cycle, plus sample=4095 with valid=0 -> level=1100,
//   speed 11->10 (one step).
//  enable=0 mid-window while at 01 -> next edge speed=11, level=0, speed_change=0;
//   re-enable restarts the window at win_cnt=0.

Source files
------------

// File: rtl/fan_speed_sel.sv
// ---------------------------------------------------------------------------
// fan_speed_sel
//   Upstream stage of the fan PWM generator. Tracks the peak audio magnitude
//   over fixed windows of WIN_US ticks, quantises each window's peak against
//   three thresholds and steps the fan speed index up or down by at most one
//   level per window. Down-steps need a hysteresis margin and a minimum dwell
//   since the last change so music transients do not make the fan chatter.
//
// Ports
//   clk_us        in   1     1 MHz system tick clock
//   rst           in   1     synchronous reset, active-high (beats enable)
//   enable        in   1     0 = force OFF and clear all state
//   sample_valid  in   1     sample qualifies this cycle
//   sample        in   SW    unsigned audio magnitude
//   speed         out  2     speed code (HIGH=00, MED=01, LOW=10, OFF=11)
//   level         out  SW    peak of the last completed window
//   speed_change  out  1     one-cycle pulse on the edge where speed changes
// ---------------------------------------------------------------------------
module fan_speed_sel #(
    parameter int SW        = 12,
    parameter int WIN_US    = 50000,
    parameter int TH_LOW    = 256,
    parameter int TH_MED    = 1024,
    parameter int TH_HIGH   = 2560,
    parameter int HYST      = 64,
    parameter int DWELL_WIN = 4
) (
    input  logic          clk_us,
    input  logic          rst,
    input  logic          enable,
    input  logic          sample_valid,
    input  logic [SW-1:0] sample,
    output logic [1:0]    speed,
    output logic [SW-1:0] level,
    output logic          speed_change
);

    localparam int CW  = (WIN_US > 1) ? $clog2(WIN_US) : 1;
    localparam int DWW = (DWELL_WIN > 0) ? $clog2(DWELL_WIN + 1) : 1;

    localparam logic [CW-1:0]  WIN_LAST  = CW'(WIN_US - 1);
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL_WIN);

    // Up thresholds, and the down thresholds (TH - HYST, saturated at zero)
    // that the window peak must fall below before leaving that level.
    localparam logic [SW-1:0] TH1 = SW'(TH_LOW);
    localparam logic [SW-1:0] TH2 = SW'(TH_MED);
    localparam logic [SW-1:0] TH3 = SW'(TH_HIGH);
    localparam logic [SW-1:0] DN1 = (TH_LOW  > HYST) ? SW'(TH_LOW  - HYST) : '0;
    localparam logic [SW-1:0] DN2 = (TH_MED  > HYST) ? SW'(TH_MED  - HYST) : '0;
    localparam logic [SW-1:0] DN3 = (TH_HIGH > HYST) ? SW'(TH_HIGH - HYST) : '0;

    // Speed index: 0=OFF, 1=LOW, 2=MED, 3=HIGH. The output code is its inverse.
    logic [CW-1:0]  win_cnt_q,      win_cnt_d;
    logic [SW-1:0]  peak_q,         peak_d;
    logic [1:0]     idx_q,          idx_d;
    logic [DWW-1:0] dwell_cnt_q,    dwell_cnt_d;
    logic [1:0]     speed_q,        speed_d;
    logic [SW-1:0]  level_q,        level_d;
    logic           speed_change_q, speed_change_d;

    logic [SW-1:0]  sample_eff;
    logic [SW-1:0]  fin;
    logic           win_end;
    logic [1:0]     rank;
    logic [SW-1:0]  down_th;
    logic           dwell_ok;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sample_eff = sample_valid ? sample : '0;
        // Running max including this cycle's sample; at window end this is the final peak.
        fin        = (sample_eff > peak_q) ? sample_eff : peak_q;
        win_end    = (win_cnt_q == WIN_LAST);
        rank       = 2'(fin >= TH1) + 2'(fin >= TH2) + 2'(fin >= TH3);
        dwell_ok   = (dwell_cnt_q >= DWELL_MAX);

        unique case (idx_q)
            2'd1:    down_th = DN1;
            2'd2:    down_th = DN2;
            2'd3:    down_th = DN3;
            default: down_th = '0;
        endcase

        win_cnt_d      = win_cnt_q;
        peak_d         = peak_q;
        idx_d          = idx_q;
        dwell_cnt_d    = dwell_cnt_q;
        level_d        = level_q;
        speed_change_d = 1'b0;

        if (!enable) begin
            // Forced OFF looks exactly like reset and never pulses speed_change.
            win_cnt_d   = '0;
            peak_d      = '0;
            idx_d       = 2'd0;
            dwell_cnt_d = '0;
            level_d     = '0;
        end else if (win_end) begin
            win_cnt_d = '0;
            peak_d    = '0;
            level_d   = fin;
            if (rank > idx_q) begin
                // Up-steps are never dwell-gated, but climb one level per window.
                idx_d          = idx_q + 2'd1;
                dwell_cnt_d    = '0;
                speed_change_d = 1'b1;
            end else if ((rank < idx_q) && (fin < down_th) && dwell_ok) begin
                idx_d          = idx_q - 2'd1;
                dwell_cnt_d    = '0;
                speed_change_d = 1'b1;
            end else if (!dwell_ok) begin
                dwell_cnt_d = dwell_cnt_q + DWW'(1);
            end
        end else begin
            win_cnt_d = win_cnt_q + CW'(1);
            peak_d    = fin;
        end

        speed_d = ~idx_d;
    end

    always_ff @(posedge clk_us) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            win_cnt_q      <= '0;
            peak_q         <= '0;
            idx_q          <= 2'd0;
            dwell_cnt_q    <= '0;
            speed_q        <= 2'b11;
            level_q        <= '0;
            speed_change_q <= 1'b0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            peak_q         <= peak_d;
            idx_q          <= idx_d;
            dwell_cnt_q    <= dwell_cnt_d;
            speed_q        <= speed_d;
            level_q        <= level_d;
            speed_change_q <= speed_change_d;
        end
    end

    assign speed        = speed_q;
    assign level        = level_q;
    assign speed_change = speed_change_q;

endmodule
